// File: rtl/alarm_melody_seq.sv
// Alarm tune sequencer: walks a fixed note ROM and drives the one-hot piezo KEY bus,
// holding each note for its beat count and inserting a silent gap after it.
module alarm_melody_seq #(
  parameter int unsigned TICKS_PER_BEAT = 25000,
  parameter int unsigned GAP_TICKS      = 2500,
  parameter int unsigned LENGTH         = 14
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic       LOOP,
  output logic [7:0] KEY,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] NOTE_IDX,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'(LENGTH - 1);
  localparam logic [31:0] GAP_LEN  = 32'(GAP_TICKS);
  localparam logic [31:0] BEAT_LEN = 32'(TICKS_PER_BEAT);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [7:0]  key_n;
  logic        busy_n, done_n, advance;
  logic [3:0]  idx_n, idx_inc;
  logic [5:0]  ent_inc, ent_first;

  // ROM entry = {note, beats-1}; note 0 is a rest, 1..8 map to C..highC.
  function automatic logic [5:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = {4'd1, 2'd0};
      4'd1:    rom = {4'd1, 2'd0};
      4'd2:    rom = {4'd5, 2'd0};
      4'd3:    rom = {4'd5, 2'd0};
      4'd4:    rom = {4'd6, 2'd0};
      4'd5:    rom = {4'd6, 2'd0};
      4'd6:    rom = {4'd5, 2'd1};
      4'd7:    rom = {4'd4, 2'd0};
      4'd8:    rom = {4'd4, 2'd0};
      4'd9:    rom = {4'd3, 2'd0};
      4'd10:   rom = {4'd2, 2'd0};
      4'd11:   rom = {4'd2, 2'd0};
      4'd12:   rom = {4'd1, 2'd1};
      4'd13:   rom = {4'd0, 2'd0};
      default: rom = 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] note_key(input logic [3:0] n);
    case (n)
      4'd1:    note_key = 8'h80;
      4'd2:    note_key = 8'h40;
      4'd3:    note_key = 8'h20;
      4'd4:    note_key = 8'h10;
      4'd5:    note_key = 8'h08;
      4'd6:    note_key = 8'h04;
      4'd7:    note_key = 8'h02;
      4'd8:    note_key = 8'h01;
      default: note_key = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] note_len(input logic [1:0] b);
    note_len = ({30'd0, b} + 32'd1) * BEAT_LEN;
  endfunction

  assign idx_inc   = NOTE_IDX + 4'd1;
  assign ent_inc   = rom(idx_inc);
  assign ent_first = rom(4'd0);
  assign DBG_STATE = state;

  // Counter holds the cycles left in the current PLAY or GAP phase; phase ends when it reads 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    key_n   = KEY;
    busy_n  = BUSY;
    done_n  = 1'b0;
    idx_n   = NOTE_IDX;
    advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          state_n = S_PLAY;
          idx_n   = 4'd0;
          cnt_n   = note_len(ent_first[1:0]);
          key_n   = note_key(ent_first[5:2]);
          busy_n  = 1'b1;
        end
      end
      S_PLAY: begin
        if (cnt == 32'd1) begin
          if (GAP_LEN != 32'd0) begin
            state_n = S_GAP;
            cnt_n   = GAP_LEN;
            key_n   = 8'h00;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt == 32'd1) advance = 1'b1;
        else              cnt_n   = cnt - 32'd1;
      end
      default: state_n = S_IDLE;
    endcase

    if (advance) begin
      if (NOTE_IDX < LAST_IDX) begin
        state_n = S_PLAY;
        idx_n   = idx_inc;
        cnt_n   = note_len(ent_inc[1:0]);
        key_n   = note_key(ent_inc[5:2]);
      end else if (LOOP) begin
        state_n = S_PLAY;
        idx_n   = 4'd0;
        cnt_n   = note_len(ent_first[1:0]);
        key_n   = note_key(ent_first[5:2]);
      end else begin
        state_n = S_IDLE;
        idx_n   = 4'd0;
        cnt_n   = 32'd0;
        key_n   = 8'h00;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
    end

    // Abort wins over everything, including a START in the same cycle.
    if (STOP) begin
      state_n = S_IDLE;
      idx_n   = 4'd0;
      cnt_n   = 32'd0;
      key_n   = 8'h00;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      cnt      <= 32'd0;
      KEY      <= 8'h00;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      NOTE_IDX <= 4'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      KEY      <= key_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
      NOTE_IDX <= idx_n;
    end
  end

endmodule

// File: tb/tb_alarm_melody_seq.sv
// Bench for alarm_melody_seq: a per-cycle expected stream is built from the tune table
// and compared cycle by cycle; two instances cover gapped and legato playback.
module tb_alarm_melody_seq;

  localparam int TPB = 4;

  logic       CLK = 1'b0;
  logic       RESET, start_a, start_b, STOP, LOOP;
  logic [7:0] key_a, key_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [3:0] idx_a, idx_b;
  logic [1:0] dbg_a, dbg_b;

  int checks   = 0;
  int failures = 0;

  // Observation word: {KEY, BUSY, DONE, NOTE_IDX}
  logic [13:0] exp_q[$];
  logic [13:0] obs_a, obs_b;
  assign obs_a = {key_a, busy_a, done_a, idx_a};
  assign obs_b = {key_b, busy_b, done_b, idx_b};

  typedef struct {
    logic [7:0] key;
    int         beats;
  } tune_t;
  tune_t tune[14];

  always #5 CLK = ~CLK;

  alarm_melody_seq #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(2), .LENGTH(14)) dut (
    .CLK(CLK), .RESET(RESET), .START(start_a), .STOP(STOP), .LOOP(LOOP),
    .KEY(key_a), .BUSY(busy_a), .DONE(done_a), .NOTE_IDX(idx_a), .DBG_STATE(dbg_a)
  );

  alarm_melody_seq #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(0), .LENGTH(14)) dut_legato (
    .CLK(CLK), .RESET(RESET), .START(start_b), .STOP(STOP), .LOOP(LOOP),
    .KEY(key_b), .BUSY(busy_b), .DONE(done_b), .NOTE_IDX(idx_b), .DBG_STATE(dbg_b)
  );

  task automatic cmp(input string nm, input int cyc, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t0+%0d: got key=%h busy=%b done=%b idx=%0d, want key=%h busy=%b done=%b idx=%0d",
               nm, cyc, act[13:6], act[5], act[4], act[3:0], exp[13:6], exp[5], exp[4], exp[3:0]);
    end
    checks++;
    if (!$onehot0(act[13:6])) begin
      failures++;
      $display("FAIL %s_onehot t0+%0d: key=%h, want at most one bit set", nm, cyc, act[13:6]);
    end
  endtask

  function automatic void push_pass(input int gap, input bit finish);
    for (int i = 0; i < 14; i++) begin
      repeat (tune[i].beats * TPB) exp_q.push_back({tune[i].key, 1'b1, 1'b0, 4'(i)});
      repeat (gap) exp_q.push_back({8'h00, 1'b1, 1'b0, 4'(i)});
    end
    if (finish) exp_q.push_back({8'h00, 1'b0, 1'b1, 4'd0});
  endfunction

  function automatic void push_idle(input int n);
    repeat (n) exp_q.push_back(14'd0);
  endfunction

  // START sampled at edge t0; entry k of exp_q is checked at t0+k. Offsets drive inputs
  // so they are sampled at edge t0+offset.
  task automatic play_check(input string nm, input bit legato, input int pulse_a,
                            input int pulse_b, input int stop_at, input int loop_clr);
    int n;
    logic [13:0] exp;
    n = exp_q.size();
    @(negedge CLK);
    if (legato) start_b = 1'b1; else start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s_queue t0+%0d: got empty queue, want entry", nm, k);
      end else begin
        exp = exp_q.pop_front();
        cmp(nm, k, legato ? obs_b : obs_a, exp);
      end
      if (legato) start_b = (k + 1 == pulse_a) || (k + 1 == pulse_b);
      else        start_a = (k + 1 == pulse_a) || (k + 1 == pulse_b);
      STOP = (k + 1 == stop_at);
      if (k + 1 == loop_clr) LOOP = 1'b0;
      @(posedge CLK); #1;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    STOP    = 1'b0;
  endtask

  initial begin
    tune[0]  = '{8'h80, 1}; tune[1]  = '{8'h80, 1}; tune[2]  = '{8'h08, 1};
    tune[3]  = '{8'h08, 1}; tune[4]  = '{8'h04, 1}; tune[5]  = '{8'h04, 1};
    tune[6]  = '{8'h08, 2}; tune[7]  = '{8'h10, 1}; tune[8]  = '{8'h10, 1};
    tune[9]  = '{8'h20, 1}; tune[10] = '{8'h40, 1}; tune[11] = '{8'h40, 1};
    tune[12] = '{8'h80, 2}; tune[13] = '{8'h00, 1};

    RESET = 1'b1; start_a = 1'b0; start_b = 1'b0; STOP = 1'b0; LOOP = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    cmp("reset_a", 0, obs_a, 14'd0);
    cmp("reset_b", 0, obs_b, 14'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Single gapped pass, DONE at t0+92
    push_pass(2, 1'b1); push_idle(3);
    play_check("pass", 1'b0, -1, -1, -1, -1);

    // Loop once, then release LOOP mid second pass: DONE at t0+184
    LOOP = 1'b1;
    push_pass(2, 1'b0); push_pass(2, 1'b1); push_idle(2);
    play_check("loop", 1'b0, -1, -1, -1, 100);

    // Abort at t0+20
    push_pass(2, 1'b1);
    while (exp_q.size() > 20) void'(exp_q.pop_back());
    push_idle(5);
    play_check("stop", 1'b0, -1, -1, 20, -1);

    // START together with STOP stays idle
    @(negedge CLK);
    start_a = 1'b1; STOP = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0; STOP = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmp("start_stop", k, obs_a, 14'd0);
      @(posedge CLK); #1;
    end

    // Extra START pulses while busy are ignored
    push_pass(2, 1'b1); push_idle(3);
    play_check("restart_ign", 1'b0, 5, 30, -1, -1);

    // Legato instance: no gaps, DONE at t0+64
    push_pass(0, 1'b1); push_idle(3);
    play_check("legato", 1'b1, -1, -1, -1, -1);

    // Reset mid-playback: outputs clear at the next edge with no DONE
    @(negedge CLK);
    start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmp("reset_mid", k, obs_a, 14'd0);
      @(posedge CLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
